// File: rtl/bunch_capture_pkg.sv
// Shared types and default widths for the bunch capture block.
// One summed record is produced per bunch strobe.
package bunch_capture_pkg;

    localparam int ADC_W_DEF      = 13;
    localparam int NSAMP_W_DEF    = 4;
    localparam int SUM_W_DEF      = ADC_W_DEF + NSAMP_W_DEF;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int BUNCH_W        = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACCUM,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [BUNCH_W-1:0]            bunch;
        logic [NSAMP_W_DEF-1:0]        nsamp;
        logic signed [SUM_W_DEF-1:0]   sum;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

endpackage

// File: rtl/bunch_capture_if.sv
// Per-bunch record stream: valid/ready handshake plus the record fields.
// The producer side is the master.
interface bunch_capture_if
    import bunch_capture_pkg::*;
#(
    parameter int SUM_W   = SUM_W_DEF,
    parameter int NSAMP_W = NSAMP_W_DEF
);
    logic                out_valid;
    logic                out_ready;
    logic [SUM_W-1:0]    out_sum;
    logic [BUNCH_W-1:0]  out_bunch;
    logic [NSAMP_W-1:0]  out_nsamp;

    modport master (
        output out_valid, out_sum, out_bunch, out_nsamp,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_sum, out_bunch, out_nsamp,
        output out_ready
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO. The head word is visible on rd_data while
// not empty; a write into a full FIFO is accepted only when a read frees a slot.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Gated so the head reads as zero whenever nothing is queued.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bunch_capture.sv
// Integrates ADC samples under each bunch strobe of a store and queues one
// {bunch, nsamp, sum} record per bunch for the downstream consumer.
module bunch_capture
    import bunch_capture_pkg::*;
#(
    parameter int ADC_W      = ADC_W_DEF,
    parameter int NSAMP_W    = NSAMP_W_DEF,
    parameter int SUM_W      = SUM_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    store_strb,
    input  logic                    bunch_strb,
    input  logic signed [ADC_W-1:0] adc_data,
    input  logic [1:0]              no_bunches,
    bunch_capture_if.master         rec,
    output logic                    overflow,
    output logic                    done
);
    localparam logic [NSAMP_W-1:0] NSAMP_MAX = '1;

    state_t                 state;
    logic [1:0]             nb_lat;
    logic [BUNCH_W-1:0]     idx;
    logic signed [SUM_W-1:0] acc;
    logic [NSAMP_W-1:0]     nsamp;

    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic signed [SUM_W-1:0] sample_ext;
    rec_t                   wr_rec;
    rec_t                   head;

    assign sample_ext = {{(SUM_W-ADC_W){adc_data[ADC_W-1]}}, adc_data};

    // Strobe falling while accumulating closes the current record.
    assign push = (state == S_ACCUM) && store_strb && !bunch_strb;
    assign pop  = rec.out_valid && rec.out_ready;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        wr_rec       = '0;
        wr_rec.bunch = idx;
        wr_rec.nsamp = nsamp;
        wr_rec.sum   = acc;
    end

    sync_fifo_fwft #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_rec),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rec.out_valid = !fifo_empty;
    assign rec.out_sum   = head.sum;
    assign rec.out_bunch = head.bunch;
    assign rec.out_nsamp = head.nsamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            nb_lat   <= '0;
            idx      <= '0;
            acc      <= '0;
            nsamp    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (drop) overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (store_strb) begin
                        state    <= S_ARMED;
                        nb_lat   <= no_bunches;
                        idx      <= '0;
                        overflow <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (!store_strb) begin
                        state <= S_IDLE;
                    end else if (bunch_strb && nb_lat != 2'd0) begin
                        state <= S_ACCUM;
                        acc   <= sample_ext;
                        nsamp <= NSAMP_W'(1);
                    end
                end
                S_ACCUM: begin
                    if (!store_strb) begin
                        state <= S_IDLE;
                    end else if (bunch_strb) begin
                        // Count saturates: further samples are discarded and flagged.
                        if (nsamp != NSAMP_MAX) begin
                            acc   <= acc + sample_ext;
                            nsamp <= nsamp + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (idx + 2'd1 == nb_lat) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_ARMED;
                    end
                end
                S_DONE: begin
                    if (!store_strb) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
